// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// bram_stream_reader: strided read sequencer for a registered-read BRAM,
// presenting words on a valid/ready stream. Optional macro: READER_LAST_EN.
// Revision: 1.0
// ============================================================================
module bram_stream_reader #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
`ifdef READER_LAST_EN
  output logic              out_last,
`endif
  input  logic              out_ready
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
`ifdef READER_LAST_EN
  localparam int ENT_W      = DATA_W + 1;
`else
  localparam int ENT_W      = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic                issue, load, done_nx;
  logic [ADDR_W-1:0]   cur_addr, stride_q, rd_hold;
  logic [CNT_W-1:0]    remaining;
  logic [RD_LATENCY-1:0] tok_vld, tok_vld_nx;
  logic [OCC_W-1:0]    occ, inflight;
  logic [OCC_W:0]      used;
  logic                credit_ok;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [ENT_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]    push_ent, head;
  logic                push, pop;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      inflight = inflight + OCC_W'(tok_vld[k]);
    end
  end

  // Credit: FIFO contents plus reads still in the RAM pipe must fit the FIFO.
  assign used      = {1'b0, occ} + {1'b0, inflight};
  assign credit_ok = (used < (OCC_W + 1)'(FIFO_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load     = 1'b0;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            load     = 1'b1;
            state_nx = S_RUN;
          end else begin
            done_nx  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == CNT_W'(1)) begin
            state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((inflight == '0) && (occ == '0)) begin
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign rdaddress = issue ? cur_addr : rd_hold;

  if (RD_LATENCY == 1) begin : g_lat1
    assign tok_vld_nx = issue;
  end else begin : g_latn
    assign tok_vld_nx = {tok_vld[RD_LATENCY-2:0], issue};
  end

  assign push = tok_vld[RD_LATENCY-1];
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr  <= '0;
      stride_q  <= '0;
      remaining <= '0;
      rd_hold   <= '0;
      tok_vld   <= '0;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      done      <= 1'b0;
    end else begin
      done    <= done_nx;
      tok_vld <= tok_vld_nx;
      if (load) begin
        cur_addr  <= base_addr;
        stride_q  <= stride;
        remaining <= count;
      end else if (issue) begin
        cur_addr  <= cur_addr + stride_q;
        remaining <= remaining - CNT_W'(1);
        rd_hold   <= cur_addr;
      end
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef READER_LAST_EN
  logic [RD_LATENCY-1:0] tok_last, tok_last_nx;
  logic                  issue_last;

  assign issue_last = issue && (remaining == CNT_W'(1));

  if (RD_LATENCY == 1) begin : g_last_lat1
    assign tok_last_nx = issue_last;
  end else begin : g_last_latn
    assign tok_last_nx = {tok_last[RD_LATENCY-2:0], issue_last};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tok_last <= '0;
    end else begin
      tok_last <= tok_last_nx;
    end
  end

  assign push_ent = {tok_last[RD_LATENCY-1], q};
  assign out_last = out_valid && head[DATA_W];
`else
  assign push_ent = q;
`endif

  // Storage needs no reset: the head is masked by occupancy.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_ent;
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_valid = (occ != '0);
  assign out_data  = out_valid ? head[DATA_W-1:0] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// Directed testbench for bram_stream_reader with a behavioural 512x32
// registered-read RAM model.
module tb_bram_stream_reader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int RL     = 1;
  localparam int CNT_W  = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] stride = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              busy, done;
  logic [ADDR_W-1:0] rdaddress;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              last_sig;

  logic [DATA_W-1:0] ram [0:511];
  logic              wren = 1'b0;
  logic [ADDR_W-1:0] wraddr = '0;
  logic [DATA_W-1:0] wdata = '0;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (wren) ram[wraddr] <= wdata;
    q <= ram[rdaddress];
  end

  bram_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RL), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .base_addr(base_addr), .stride(stride), .count(count),
    .busy(busy), .done(done), .rdaddress(rdaddress), .q(q),
    .out_data(out_data), .out_valid(out_valid),
`ifdef READER_LAST_EN
    .out_last(last_sig),
`endif
    .out_ready(out_ready)
  );

`ifndef READER_LAST_EN
  assign last_sig = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] got[$];
  logic              got_last[$];
  logic [ADDR_W-1:0] addr_log[$];
  int n_done, done_cyc, busy_cyc, first_vld, stall_err, valid_seen;
  bit timed_out;
  bit rpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Issues one command in the current cycle and records the stream until done+tail.
  task automatic run_cmd(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s,
                         input logic [CNT_W-1:0] c, input bit bp, input int tail);
    logic pv, pr;
    logic [DATA_W-1:0] pd;
    got.delete(); got_last.delete(); addr_log.delete();
    n_done = 0; done_cyc = -1; busy_cyc = 0; first_vld = -1;
    stall_err = 0; valid_seen = 0; timed_out = 0;
    base_addr = b; stride = s; count = c; start = 1'b1; out_ready = 1'b1;
    pv = 1'b0; pr = 1'b1; pd = '0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      out_ready = bp ? rpat[(i - 1) % 6] : 1'b1;
      addr_log.push_back(rdaddress);
      if (busy) busy_cyc++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = i;
      end
      if (out_valid) begin
        valid_seen = 1;
        if (first_vld < 0) first_vld = i;
      end
      if (pv && !pr && (!out_valid || out_data !== pd)) stall_err++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        got_last.push_back(last_sig);
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (done_cyc >= 0 && i >= done_cyc + tail) break;
    end
    if (done_cyc < 0) timed_out = 1;
  endtask

  task automatic preload();
    for (int k = 0; k < 512; k++) begin
      @(posedge clock); #1;
      wren = 1'b1; wraddr = ADDR_W'(k); wdata = 32'h1000_0000 + k;
    end
    @(posedge clock); #1;
    wren = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (rdaddress !== '0) begin bad++; $display("FAIL reset_rdaddr got=%0d want=0", rdaddress); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
`ifdef READER_LAST_EN
    total++; if (last_sig !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", last_sig); end
`endif
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    logic [DATA_W-1:0] obs;
    run_cmd(9'd0, 9'd1, 10'd4, 1'b0, 2);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=none want=done"); end
    total++; if (got.size() !== 4) begin bad++; $display("FAIL basic_count got=%0d want=4", got.size()); end
    for (int k = 0; k < 4; k++) begin
      obs = (k < got.size()) ? got[k] : 'x;
      total++;
      if (obs !== 32'h1000_0000 + k) begin
        bad++; $display("FAIL basic_data[%0d] got=%h want=%h", k, obs, 32'h1000_0000 + k);
      end
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", n_done); end
    total++; if (busy_cyc !== 4 + RL + 2) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=%0d", busy_cyc, 4 + RL + 2); end
    total++; if (first_vld !== 2 + RL) begin bad++; $display("FAIL basic_first_latency got=%0d want=%0d", first_vld, 2 + RL); end
    total++; if (done_cyc !== 7 + RL) begin bad++; $display("FAIL basic_done_cycle got=%0d want=%0d", done_cyc, 7 + RL); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] ea [4] = '{9'd510, 9'd511, 9'd0, 9'd1};
    logic [DATA_W-1:0] ed [4] = '{32'h1000_01FE, 32'h1000_01FF, 32'h1000_0000, 32'h1000_0001};
    logic [ADDR_W-1:0] oa;
    logic [DATA_W-1:0] od;
    run_cmd(9'd510, 9'd1, 10'd4, 1'b0, 1);
    total++; if (timed_out) begin bad++; $display("FAIL wrap_timeout got=none want=done"); end
    for (int k = 0; k < 4; k++) begin
      oa = (k < addr_log.size()) ? addr_log[k] : 'x;
      od = (k < got.size()) ? got[k] : 'x;
      total++; if (oa !== ea[k]) begin bad++; $display("FAIL wrap_addr[%0d] got=%0d want=%0d", k, oa, ea[k]); end
      total++; if (od !== ed[k]) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", k, od, ed[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] obs;
    run_cmd(9'd8, 9'd3, 10'd6, 1'b1, 1);
    total++; if (timed_out) begin bad++; $display("FAIL bp_timeout got=none want=done"); end
    total++; if (got.size() !== 6) begin bad++; $display("FAIL bp_count got=%0d want=6", got.size()); end
    for (int k = 0; k < 6; k++) begin
      obs = (k < got.size()) ? got[k] : 'x;
      total++;
      if (obs !== 32'h1000_0008 + 3 * k) begin
        bad++; $display("FAIL bp_data[%0d] got=%h want=%h", k, obs, 32'h1000_0008 + 3 * k);
      end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", stall_err); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL bp_done_pulses got=%0d want=1", n_done); end
  endtask

  task automatic test_degenerate();
    logic [DATA_W-1:0] obs;
    run_cmd(9'd7, 9'd1, 10'd0, 1'b0, 3);
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle got=%0d want=1", done_cyc); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", n_done); end
    total++; if (busy_cyc !== 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_cyc); end
    total++; if (valid_seen !== 0) begin bad++; $display("FAIL zero_valid got=%0d want=0", valid_seen); end
    run_cmd(9'd5, 9'd0, 10'd3, 1'b0, 1);
    total++; if (got.size() !== 3) begin bad++; $display("FAIL stride0_count got=%0d want=3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      obs = (k < got.size()) ? got[k] : 'x;
      total++; if (obs !== 32'h1000_0005) begin bad++; $display("FAIL stride0_data[%0d] got=%h want=10000005", k, obs); end
    end
  endtask

  task automatic test_reset_midrun();
    int nd, nv;
    nd = 0; nv = 0;
    base_addr = 9'd0; stride = 9'd1; count = 10'd16; start = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (i == 6) reset = 1'b1;
      if (i == 7) begin
        reset = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (rdaddress !== '0) begin bad++; $display("FAIL abort_rdaddr got=%0d want=0", rdaddress); end
      end
      if (i >= 7) begin
        if (done) nd++;
        if (out_valid) nv++;
      end
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL abort_done got=%0d want=0", nd); end
    total++; if (nv !== 0) begin bad++; $display("FAIL abort_stale_valid got=%0d want=0", nv); end
    run_cmd(9'd100, 9'd2, 10'd2, 1'b0, 1);
    total++; if (got.size() !== 2) begin bad++; $display("FAIL after_abort_count got=%0d want=2", got.size()); end
    total++; if (got.size() < 1 || got[0] !== 32'h1000_0064) begin bad++; $display("FAIL after_abort_w0 got=%h want=10000064", got.size() > 0 ? got[0] : 'x); end
    total++; if (got.size() < 2 || got[1] !== 32'h1000_0066) begin bad++; $display("FAIL after_abort_w1 got=%h want=10000066", got.size() > 1 ? got[1] : 'x); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL after_abort_done got=%0d want=1", n_done); end
  endtask

  task automatic test_back_to_back();
    logic first_last [$];
    logic [DATA_W-1:0] obs;
    logic ol;
    run_cmd(9'd0, 9'd1, 10'd4, 1'b0, 1);
    first_last = got_last;
    run_cmd(9'd20, 9'd1, 10'd3, 1'b0, 2);
    total++; if (timed_out) begin bad++; $display("FAIL b2b_timeout got=none want=done"); end
    total++; if (got.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", got.size()); end
    for (int k = 0; k < 3; k++) begin
      obs = (k < got.size()) ? got[k] : 'x;
      total++; if (obs !== 32'h1000_0014 + k) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, obs, 32'h1000_0014 + k); end
    end
    total++; if (first_vld !== 2 + RL) begin bad++; $display("FAIL b2b_first_latency got=%0d want=%0d", first_vld, 2 + RL); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=1", n_done); end
`ifdef READER_LAST_EN
    for (int k = 0; k < 4; k++) begin
      ol = (k < first_last.size()) ? first_last[k] : 1'bx;
      total++; if (ol !== (k == 3)) begin bad++; $display("FAIL last_cmd1[%0d] got=%b want=%b", k, ol, (k == 3)); end
    end
    for (int k = 0; k < 3; k++) begin
      ol = (k < got_last.size()) ? got_last[k] : 1'bx;
      total++; if (ol !== (k == 2)) begin bad++; $display("FAIL last_cmd2[%0d] got=%b want=%b", k, ol, (k == 2)); end
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    preload();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_degenerate();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
